// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a 5-stage RV32I pipeline. Owns the fetch PC and
// the next-PC select, drives a synchronous-read instruction memory, and
// registers the IF/ID boundary (PC_D, PCPlus4_D, Valid_D). Because memory
// data arrives one cycle after its address, the fetched word is captured into
// a hold register when decode stalls, so Instr_D stays paired with PC_D for
// the whole stall.
//
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous, active-high reset
//   PCSrc_E     in   redirect request from execute (taken branch / jump)
//   PCTarget_E  in   redirect target from execute (low two bits ignored)
//   Stall_F     in   hold the fetch PC
//   Stall_D     in   hold the IF/ID registers
//   Flush_D     in   replace the IF/ID contents with a bubble
//   IMemAddr_F  out  instruction memory address (= PC_F, combinational)
//   IMemRdata   in   instruction memory read data, valid one cycle later
//   Instr_D     out  instruction presented to decode
//   PC_D        out  PC of Instr_D
//   PCPlus4_D   out  PC_D + 4
//   Valid_D     out  1 = real fetched instruction, 0 = bubble
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc_E,
    input  logic [31:0] PCTarget_E,
    input  logic        Stall_F,
    input  logic        Stall_D,
    input  logic        Flush_D,
    output logic [31:0] IMemAddr_F,
    input  logic [31:0] IMemRdata,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PCPlus4_D,
    output logic        Valid_D
);

    logic [31:0] pc_f_q,       pc_f_d;
    logic [31:0] pc_id_q,      pc_id_d;
    logic [31:0] pcplus4_id_q, pcplus4_id_d;
    logic        valid_id_q,   valid_id_d;
    logic [31:0] hold_reg_q,   hold_reg_d;
    logic        hold_valid_q, hold_valid_d;

    logic [31:0] pc_f_plus4;

    // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
    assign pc_f_plus4 = pc_f_q + 32'd4;

    // Next fetch PC: a redirect wins over a fetch stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pc_f_d = pc_f_plus4;
        if (PCSrc_E) begin
            pc_f_d = {PCTarget_E[31:2], 2'b00};
        end else if (Stall_F) begin
            pc_f_d = pc_f_q;
        end
    end

    // IF/ID boundary plus stall hold register. Flush wins over stall.
    always_comb begin
        pc_id_d      = pc_id_q;
        pcplus4_id_d = pcplus4_id_q;
        valid_id_d   = valid_id_q;
        hold_reg_d   = hold_reg_q;
        hold_valid_d = hold_valid_q;

        if (Flush_D) begin
            pc_id_d      = 32'd0;
            pcplus4_id_d = 32'd0;
            valid_id_d   = 1'b0;
            hold_valid_d = 1'b0;
        end else if (Stall_D) begin
            // Memory data for PC_D is only on IMemRdata during the first stalled
            // cycle; grab it then, before the address moves on. Bubbles need no copy.
            if (!hold_valid_q && valid_id_q) begin
                hold_reg_d   = IMemRdata;
                hold_valid_d = 1'b1;
            end
        end else begin
            pc_id_d      = pc_f_q;
            pcplus4_id_d = pc_f_plus4;
            valid_id_d   = 1'b1;
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            pc_f_q       <= RESET_PC;
            pc_id_q      <= 32'd0;
            pcplus4_id_q <= 32'd0;
            valid_id_q   <= 1'b0;
            hold_reg_q   <= 32'd0;
            hold_valid_q <= 1'b0;
        end else begin
            pc_f_q       <= pc_f_d;
            pc_id_q      <= pc_id_d;
            pcplus4_id_q <= pcplus4_id_d;
            valid_id_q   <= valid_id_d;
            hold_reg_q   <= hold_reg_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign IMemAddr_F = pc_f_q;
    assign PC_D       = pc_id_q;
    assign PCPlus4_D  = pcplus4_id_q;
    assign Valid_D    = valid_id_q;

    always_comb begin
        if (!valid_id_q) begin
            Instr_D = NOP_INSTR;
        end else if (hold_valid_q) begin
            Instr_D = hold_reg_q;
        end else begin
            Instr_D = IMemRdata;
        end
    end

endmodule
